// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one uart_tx serializer among NUM_REQ byte producers.
// One byte is granted at a time. It is strobed into the serializer, and then
// the arbiter waits FRAME_TICKS+GAP_TICKS baud_x1 ticks before the next grant.
// Build option: define UART_TX_ARB_PRIORITY_EN for fixed lowest-index-wins
// priority. The default build uses round-robin selection.
module uart_tx_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int FRAME_TICKS = 11,
  parameter int GAP_TICKS   = 0,
  localparam int GID_W      = $clog2(NUM_REQ),
  localparam int CNT_W      = $clog2(FRAME_TICKS + GAP_TICKS + 1)
) (
  input  logic                 mclk,
  input  logic                 reset_n,
  input  logic                 baud_x1,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [7:0]           tx_data,
  output logic                 tx_strobe,
  output logic                 busy,
  output logic [GID_W-1:0]     grant_id
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] TICKS_LOAD = CNT_W'(FRAME_TICKS + GAP_TICKS);
  localparam logic [GID_W-1:0] GID_RESET  = GID_W'(NUM_REQ - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic [GID_W-1:0] grant_id_q, grant_id_d;

  logic [7:0]       req_bytes [NUM_REQ];
  logic [GID_W-1:0] winner;
  logic             any_valid;

  // Split the packed request bus into one byte per requester.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_bytes
      assign req_bytes[gi] = req_data[8*gi +: 8];
    end
  endgenerate

  assign any_valid = |req_valid;

`ifdef UART_TX_ARB_PRIORITY_EN
  // Fixed priority: the lowest-index valid requester wins.
  always_comb begin
    winner = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_valid[GID_W'(k)]) winner = GID_W'(k);
    end
  end
`else
  logic [GID_W-1:0] cand;
  logic             found;

  // Round-robin: search from the requester after the last grant and wrap.
  always_comb begin
    winner = grant_id_q;
    found  = 1'b0;
    cand   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = GID_W'((int'(grant_id_q) + k) % NUM_REQ);
      if (!found && req_valid[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end
`endif

  // Next state and outputs. Grants are suppressed while reset is asserted,
  // so nothing is accepted during a reset cycle.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    tx_data_d  = tx_data_q;
    grant_id_d = grant_id_q;
    req_ready  = '0;
    tx_strobe  = 1'b0;
    busy       = (state_q != ST_IDLE);
    case (state_q)
      ST_IDLE: begin
        if (reset_n && any_valid) begin
          req_ready  = NUM_REQ'(1) << winner;
          tx_data_d  = req_bytes[winner];
          grant_id_d = winner;
          state_d    = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // A baud_x1 tick arriving here is ignored, so the count cannot underflow.
        tx_strobe = 1'b1;
        cnt_d     = TICKS_LOAD;
        state_d   = ST_WAIT;
      end
      ST_WAIT: begin
        if (baud_x1) begin
          if (cnt_q <= CNT_W'(1)) begin
            cnt_d   = '0;
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers with a synchronous active-low reset.
  always_ff @(posedge mclk) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      tx_data_q  <= 8'h00;
      grant_id_q <= GID_RESET;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tx_data_q  <= tx_data_d;
      grant_id_q <= grant_id_d;
    end
  end

  assign tx_data  = tx_data_q;
  assign grant_id = grant_id_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter: directed scenarios followed by random traffic.
// A cycle-level reference model predicts grants and strobes into queues, and a
// monitor compares them with the DUT at each falling edge.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;
  localparam int N  = 4;
  localparam int FT = 11;
  localparam int GT = 2;
  localparam int GW = $clog2(N);

  logic           mclk = 1'b0;
  logic           reset_n = 1'b0;
  logic           baud_x1 = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [8*N-1:0] req_data = '0;
  logic [N-1:0]   req_ready;
  logic [7:0]     tx_data;
  logic           tx_strobe;
  logic           busy;
  logic [GW-1:0]  grant_id;

  always #5 mclk = ~mclk;

  uart_tx_arbiter #(.NUM_REQ(N), .FRAME_TICKS(FT), .GAP_TICKS(GT)) dut (
    .mclk(mclk), .reset_n(reset_n), .baud_x1(baud_x1),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .tx_data(tx_data), .tx_strobe(tx_strobe), .busy(busy), .grant_id(grant_id)
  );

  int cyc = 0;
  always @(posedge mclk) cyc <= cyc + 1;

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
  endtask

  // Scoreboard queues filled by the model.
  typedef struct { int cyc; logic [N-1:0] onehot; } gexp_t;
  typedef struct { int cyc; logic [7:0] data; int id; } sexp_t;
  gexp_t gq[$];
  sexp_t sq[$];

  // Next-cycle stimulus chosen by the scenario code.
  bit         n_rst = 1'b0;
  logic [N-1:0] n_valid = '0;
  logic [7:0] n_byte [N];
  bit         baud_random = 1'b0;

  // Reference model: the arbiter is either free, or occupied for one strobe
  // cycle followed by FT+GT baud ticks.
  bit         m_free = 1'b1;
  bit         m_issuing = 1'b0;
  int         m_left = 0;
  int         m_gid = N - 1;
  logic [7:0] m_txdata = 8'h00;
  int         granted = -1;

  // Per-cycle expectations read by the monitor.
  bit         chk_en = 1'b0;
  logic       e_busy = 1'b0;
  logic [GW-1:0] e_gid = '0;
  logic [7:0] e_txdata = 8'h00;

  bit win_flag = 1'b0;
  int ready1_seen = 0;

  function automatic int pick();
`ifdef UART_TX_ARB_PRIORITY_EN
    for (int i = 0; i < N; i++) if (req_valid[i]) return i;
`else
    for (int i = 1; i <= N; i++) if (req_valid[(m_gid + i) % N]) return (m_gid + i) % N;
`endif
    return -1;
  endfunction

  task automatic model_eval();
    int w;
    e_busy   = !m_free;
    e_gid    = m_gid[GW-1:0];
    e_txdata = m_txdata;
    granted  = -1;
    w = -1;
    if (reset_n && m_free && (req_valid != '0)) begin
      w = pick();
      granted = w;
      gq.push_back('{cyc, N'(1) << w});
      sq.push_back('{cyc + 1, n_byte[w], w});
    end
    if (!reset_n) begin
      m_free = 1'b1; m_issuing = 1'b0; m_left = 0; m_gid = N - 1; m_txdata = 8'h00;
    end else if (w >= 0) begin
      m_free = 1'b0; m_issuing = 1'b1; m_gid = w; m_txdata = n_byte[w];
    end else if (m_issuing) begin
      m_issuing = 1'b0; m_left = FT + GT;
    end else if (!m_free && baud_x1) begin
      m_left--;
      if (m_left == 0) m_free = 1'b1;
    end
  endtask

  task automatic step();
    @(posedge mclk);
    #1;
    reset_n   = n_rst;
    req_valid = n_valid;
    for (int i = 0; i < N; i++) req_data[8*i +: 8] = n_byte[i];
    if (baud_random) baud_x1 = !baud_x1 && ($urandom_range(0, 3) == 0);
    else             baud_x1 = ((cyc % 16) == 0);
    model_eval();
    chk_en = 1'b1;
  endtask

  task automatic wait_grant(input int id, input int bound);
    int k = 0;
    step();
    while (granted != id && k < bound) begin step(); k++; end
    chk("wait_grant", (granted == id), 1);
  endtask

  task automatic wait_free(input int bound);
    int k = 0;
    while (!m_free && k < bound) begin step(); k++; end
    chk("wait_free", m_free, 1);
  endtask

  // Monitor: compares registered outputs and handshake events each falling edge.
  initial begin
    gexp_t g;
    sexp_t s;
    forever begin
      @(negedge mclk);
      if (chk_en) begin
        chk("busy", busy, e_busy);
        chk("grant_id", grant_id, e_gid);
        chk("tx_data", tx_data, e_txdata);
        if (win_flag && req_ready[1]) ready1_seen++;
        if (gq.size() > 0 && gq[0].cyc == cyc) begin
          g = gq.pop_front();
          chk("req_ready", req_ready, g.onehot);
        end else if (req_ready != '0) begin
          chk("req_ready_unexpected", req_ready, 0);
        end
        if (sq.size() > 0 && sq[0].cyc == cyc) begin
          s = sq.pop_front();
          chk("tx_strobe", tx_strobe, 1);
          chk("strobe_data", tx_data, s.data);
          chk("strobe_id", grant_id, s.id);
        end else if (tx_strobe) begin
          chk("tx_strobe_unexpected", tx_strobe, 0);
        end
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int grants;
    int k;
    for (int i = 0; i < N; i++) n_byte[i] = 8'h10 + 8'(i);

    // Reset held with every requester valid, then continuous round-robin traffic.
    n_rst = 1'b0; n_valid = '1;
    repeat (4) step();
    n_rst = 1'b1;
    grants = 0; k = 0;
    while (grants < 8 && k < 4000) begin
      step();
      if (granted >= 0) grants++;
      k++;
    end
    chk("rr_grants", grants, 8);
    n_valid = '0;
    wait_free(400);

    // Single byte from requester 2.
    n_byte[2] = 8'hA5; n_valid = 4'b0100;
    wait_grant(2, 50);
    n_valid = '0;
    wait_free(400);

    // Requester 1 pulses valid only while the arbiter is busy.
    n_byte[0] = 8'h3C; n_valid = 4'b0001;
    wait_grant(0, 50);
    n_valid = '0;
    win_flag = 1'b1;
    repeat (20) step();
    n_byte[1] = 8'h77; n_valid = 4'b0010;
    repeat (5) step();
    n_valid = '0;
    wait_free(400);
    repeat (5) step();
    win_flag = 1'b0;
    chk("withdrawn_r1", ready1_seen, 0);

    // Reset in the middle of a frame, then an immediate new grant.
    n_byte[3] = 8'h5A; n_valid = 4'b1000;
    wait_grant(3, 50);
    n_valid = '0;
    repeat (30) step();
    n_rst = 1'b0;
    step();
    n_rst = 1'b1; n_byte[2] = 8'h99; n_valid = 4'b0100;
    step();
    chk("grant_after_reset", granted, 2);
    n_valid = '0;
    wait_free(400);

    // Random traffic with random baud ticks, withdrawals and occasional resets.
    baud_random = 1'b1;
    repeat (3000) begin
      step();
      n_rst = ($urandom_range(0, 999) != 0);
      for (int i = 0; i < N; i++) begin
        if (granted == i) begin
          n_valid[i] = $urandom_range(0, 1);
          n_byte[i]  = 8'($urandom);
        end else if (!n_valid[i]) begin
          if ($urandom_range(0, 7) == 0) begin
            n_valid[i] = 1'b1;
            n_byte[i]  = 8'($urandom);
          end
        end else if ($urandom_range(0, 63) == 0) begin
          n_valid[i] = 1'b0;
        end
      end
    end
    n_rst = 1'b1; n_valid = '0;
    wait_free(400);
    repeat (3) step();
    @(negedge mclk);
    #1;
    chk("grant_queue_empty", gq.size(), 0);
    chk("strobe_queue_empty", sq.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
